// File: rtl/pong_pkg.sv
// Shared types for the object hit scheduler: coordinate widths, FSM encoding
// and the object-table entry record.
package pong_pkg;

  localparam int unsigned X_W         = 10;
  localparam int unsigned Y_W         = 9;
  localparam int unsigned SZ_W        = 4;
  localparam int unsigned NUM_OBJ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic            en;
    logic            dotted;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [SZ_W-1:0] w;
    logic [SZ_W-1:0] h;
  } obj_entry_t;

endpackage

// File: rtl/obj_hit_test.sv
// Combinational test of one object-table entry against a pixel position:
// solid boxes report hit, dotted columns report hit or gap.
module obj_hit_test
  import pong_pkg::*;
(
  input  obj_entry_t       entry,
  input  logic [X_W-1:0]   px,
  input  logic [Y_W-1:0]   py,
  output logic             hit,
  output logic             gap
);

  logic [X_W:0]   x_end;
  logic [Y_W:0]   y_end;
  logic           in_x;
  logic           in_y;
  logic [Y_W-1:0] period;
  logic [Y_W-1:0] phase;
  logic           stripe_on;

  always_comb begin
    // Extents are one bit wider so objects near the screen edge never wrap.
    x_end  = {1'b0, entry.x} + {{(X_W + 1 - SZ_W){1'b0}}, entry.w};
    y_end  = {1'b0, entry.y} + {{(Y_W + 1 - SZ_W){1'b0}}, entry.h};
    in_x   = entry.en && (px >= entry.x) && ({1'b0, px} <= x_end);
    in_y   = (py >= entry.y) && ({1'b0, py} <= y_end);

    period    = {{(Y_W - SZ_W - 1){1'b0}}, entry.w, 1'b0};
    phase     = (entry.w == '0) ? '0 : (py % period);
    stripe_on = phase < {{(Y_W - SZ_W){1'b0}}, entry.w};

    hit = 1'b0;
    gap = 1'b0;
    if (entry.dotted) begin
      if (in_x && (entry.w != '0)) begin
        hit = stripe_on;
        gap = !stripe_on;
      end
    end else begin
      hit = in_x && in_y;
    end
  end

endmodule

// File: rtl/object_hit_scheduler.sv
// Scans the object table one entry per cycle for a polled pixel and reports
// the lowest-index hit, or the first dotted-column gap as an alternate result.
module object_hit_scheduler
  import pong_pkg::*;
#(
  parameter int unsigned NUM_OBJ = NUM_OBJ_DEF,
  parameter int unsigned IDX_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic             cfg_dotted,
  input  logic [X_W-1:0]   cfg_x,
  input  logic [Y_W-1:0]   cfg_y,
  input  logic [SZ_W-1:0]  cfg_w,
  input  logic [SZ_W-1:0]  cfg_h,
  input  logic             poll_valid,
  output logic             poll_ready,
  input  logic [X_W-1:0]   poll_x,
  input  logic [Y_W-1:0]   poll_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_hit,
  output logic             res_alt,
  output logic [IDX_W-1:0] res_id
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

  obj_entry_t table_q [NUM_OBJ];

  scan_state_t      state_q, state_d;
  logic [X_W-1:0]   px_q, px_d;
  logic [Y_W-1:0]   py_q, py_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic             scan_more_q, scan_more_d;
  logic             stg_vld_q, stg_vld_d;
  logic             stg_hit_q, stg_hit_d;
  logic             stg_gap_q, stg_gap_d;
  logic             stg_last_q, stg_last_d;
  logic [IDX_W-1:0] stg_id_q, stg_id_d;
  logic             alt_vld_q, alt_vld_d;
  logic [IDX_W-1:0] alt_id_q, alt_id_d;
  logic             res_hit_q, res_hit_d;
  logic             res_alt_q, res_alt_d;
  logic [IDX_W-1:0] res_id_q, res_id_d;

  logic             eval_hit;
  logic             eval_gap;

  obj_hit_test u_hit_test (
    .entry (table_q[scan_idx_q]),
    .px    (px_q),
    .py    (py_q),
    .hit   (eval_hit),
    .gap   (eval_gap)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
        table_q[i] <= '0;
      end
    end else if (cfg_we) begin
      table_q[cfg_idx] <= {cfg_en, cfg_dotted, cfg_x, cfg_y, cfg_w, cfg_h};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      px_q        <= '0;
      py_q        <= '0;
      scan_idx_q  <= '0;
      scan_more_q <= 1'b0;
      stg_vld_q   <= 1'b0;
      stg_hit_q   <= 1'b0;
      stg_gap_q   <= 1'b0;
      stg_last_q  <= 1'b0;
      stg_id_q    <= '0;
      alt_vld_q   <= 1'b0;
      alt_id_q    <= '0;
      res_hit_q   <= 1'b0;
      res_alt_q   <= 1'b0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      scan_idx_q  <= scan_idx_d;
      scan_more_q <= scan_more_d;
      stg_vld_q   <= stg_vld_d;
      stg_hit_q   <= stg_hit_d;
      stg_gap_q   <= stg_gap_d;
      stg_last_q  <= stg_last_d;
      stg_id_q    <= stg_id_d;
      alt_vld_q   <= alt_vld_d;
      alt_id_q    <= alt_id_d;
      res_hit_q   <= res_hit_d;
      res_alt_q   <= res_alt_d;
      res_id_q    <= res_id_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    scan_idx_d  = scan_idx_q;
    scan_more_d = scan_more_q;
    stg_vld_d   = stg_vld_q;
    stg_hit_d   = stg_hit_q;
    stg_gap_d   = stg_gap_q;
    stg_last_d  = stg_last_q;
    stg_id_d    = stg_id_q;
    alt_vld_d   = alt_vld_q;
    alt_id_d    = alt_id_q;
    res_hit_d   = res_hit_q;
    res_alt_d   = res_alt_q;
    res_id_d    = res_id_q;

    unique case (state_q)
      IDLE: begin
        if (poll_valid) begin
          state_d     = SCAN;
          px_d        = poll_x;
          py_d        = poll_y;
          scan_idx_d  = '0;
          scan_more_d = 1'b1;
          stg_vld_d   = 1'b0;
          alt_vld_d   = 1'b0;
          alt_id_d    = '0;
        end
      end

      SCAN: begin
        // Each entry's test result is registered and acted on one cycle
        // later; the entry evaluated meanwhile is simply dropped on a hit.
        if (scan_more_q) begin
          stg_vld_d   = 1'b1;
          stg_hit_d   = eval_hit;
          stg_gap_d   = eval_gap;
          stg_id_d    = scan_idx_q;
          stg_last_d  = (scan_idx_q == LAST_IDX);
          scan_more_d = (scan_idx_q != LAST_IDX);
          scan_idx_d  = scan_idx_q + IDX_W'(1);
        end else begin
          stg_vld_d   = 1'b0;
        end

        if (stg_vld_q) begin
          if (stg_hit_q) begin
            state_d   = DONE;
            res_hit_d = 1'b1;
            res_alt_d = 1'b0;
            res_id_d  = stg_id_q;
          end else begin
            if (stg_gap_q && !alt_vld_q) begin
              alt_vld_d = 1'b1;
              alt_id_d  = stg_id_q;
            end
            if (stg_last_q) begin
              state_d   = DONE;
              res_hit_d = 1'b0;
              res_alt_d = alt_vld_q || stg_gap_q;
              res_id_d  = alt_vld_q ? alt_id_q : (stg_gap_q ? stg_id_q : '0);
            end
          end
        end
      end

      DONE: begin
        if (res_ready) begin
          state_d   = IDLE;
          res_hit_d = 1'b0;
          res_alt_d = 1'b0;
          res_id_d  = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign poll_ready = reset && (state_q == IDLE);
  assign res_valid  = (state_q == DONE);
  assign res_hit    = res_valid && res_hit_q;
  assign res_alt    = res_valid && res_alt_q;
  assign res_id     = res_valid ? res_id_q : '0;

endmodule

// File: tb/tb_object_hit_scheduler.sv
// Self-checking bench for object_hit_scheduler: a cycle-level behavioural
// model checked every cycle, plus hand-computed directed expectations.
module tb_object_hit_scheduler;
  import pong_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic       cfg_en;
  logic       cfg_dotted;
  logic [9:0] cfg_x;
  logic [8:0] cfg_y;
  logic [3:0] cfg_w;
  logic [3:0] cfg_h;
  logic       poll_valid;
  logic       poll_ready;
  logic [9:0] poll_x;
  logic [8:0] poll_y;
  logic       res_valid;
  logic       res_ready;
  logic       res_hit;
  logic       res_alt;
  logic [1:0] res_id;

  object_hit_scheduler #(.NUM_OBJ(4), .IDX_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_en     (cfg_en),
    .cfg_dotted (cfg_dotted),
    .cfg_x      (cfg_x),
    .cfg_y      (cfg_y),
    .cfg_w      (cfg_w),
    .cfg_h      (cfg_h),
    .poll_valid (poll_valid),
    .poll_ready (poll_ready),
    .poll_x     (poll_x),
    .poll_y     (poll_y),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_hit    (res_hit),
    .res_alt    (res_alt),
    .res_id     (res_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: object table, plus the outcome of the poll in flight.
  int t_en[N], t_dot[N], t_x[N], t_y[N], t_w[N], t_h[N];
  bit m_known = 0;
  bit m_busy = 0, m_valid = 0, m_found = 0, m_gapped = 0;
  bit m_hit = 0, m_alt = 0;
  int m_cyc = 0, m_when = -1, m_px = 0, m_py = 0, m_id = 0, m_gap_id = 0;

  bit s_ready, s_valid, s_hit, s_alt;
  int s_id;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void eval_entry(int i, int px, int py, output bit hit, output bit gap);
    bit inx;
    hit = 0;
    gap = 0;
    inx = (t_en[i] != 0) && (px >= t_x[i]) && (px <= t_x[i] + t_w[i]);
    if (t_dot[i] == 0) begin
      hit = inx && (py >= t_y[i]) && (py <= t_y[i] + t_h[i]);
    end else if (inx && t_w[i] != 0) begin
      if ((py % (2 * t_w[i])) < t_w[i]) hit = 1;
      else gap = 1;
    end
  endfunction

  // One clock cycle: sample and compare at negedge, advance the model to the
  // next rising edge, then return just after that edge.
  task automatic cycle();
    bit h, g;
    @(negedge clk);
    s_ready = poll_ready;
    s_valid = res_valid;
    s_hit   = res_hit;
    s_alt   = res_alt;
    s_id    = int'(res_id);
    if (m_known) begin
      chk("poll_ready", int'(s_ready), int'(reset && !m_busy && !m_valid));
      chk("res_valid",  int'(s_valid), int'(m_valid));
      chk("res_hit",    int'(s_hit),   m_valid ? int'(m_hit) : 0);
      chk("res_alt",    int'(s_alt),   m_valid ? int'(m_alt) : 0);
      chk("res_id",     s_id,          m_valid ? m_id : 0);
    end
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        t_en[i] = 0; t_dot[i] = 0; t_x[i] = 0; t_y[i] = 0; t_w[i] = 0; t_h[i] = 0;
      end
      m_busy  = 0;
      m_valid = 0;
      m_known = 1;
    end else begin
      if (m_valid) begin
        if (res_ready) m_valid = 0;
      end else if (m_busy) begin
        if (m_cyc < N && !m_found) begin
          eval_entry(m_cyc, m_px, m_py, h, g);
          if (h) begin
            m_found = 1; m_hit = 1; m_alt = 0; m_id = m_cyc; m_when = m_cyc + 2;
          end else begin
            if (g && !m_gapped) begin
              m_gapped = 1; m_gap_id = m_cyc;
            end
            if (m_cyc == N - 1) begin
              m_when = N + 1; m_hit = 0; m_alt = m_gapped; m_id = m_gapped ? m_gap_id : 0;
            end
          end
        end
        m_cyc++;
        if (m_cyc == m_when) begin
          m_busy  = 0;
          m_valid = 1;
        end
      end else if (poll_valid) begin
        m_busy = 1; m_cyc = 0; m_px = int'(poll_x); m_py = int'(poll_y);
        m_found = 0; m_gapped = 0; m_when = -1;
      end
      if (cfg_we) begin
        t_en[cfg_idx] = cfg_en;  t_dot[cfg_idx] = cfg_dotted;
        t_x[cfg_idx]  = cfg_x;   t_y[cfg_idx]   = cfg_y;
        t_w[cfg_idx]  = cfg_w;   t_h[cfg_idx]   = cfg_h;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(int idx, bit en, bit dot, int x, int y, int w, int h);
    cfg_idx = 2'(idx); cfg_en = en; cfg_dotted = dot;
    cfg_x = 10'(x); cfg_y = 9'(y); cfg_w = 4'(w); cfg_h = 4'(h);
  endtask

  task automatic set_entry(int idx, bit en, bit dot, int x, int y, int w, int h);
    load_cfg(idx, en, dot, x, y, w, h);
    cfg_we = 1;
    cycle();
    cfg_we = 0;
  endtask

  // Issue one poll; cfg_we is pulsed during scan cycle wr_at (if >= 0) with
  // whatever the cfg_* fields already hold.
  task automatic poll(int px, int py, int wr_at, output bit hit, output bit alt,
                      output int id, output int lat);
    bit acc;
    acc = 0; hit = 0; alt = 0; id = -1; lat = -1;
    poll_x = 10'(px); poll_y = 9'(py); poll_valid = 1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (s_ready) begin
        acc = 1;
        break;
      end
    end
    poll_valid = 0;
    if (!acc) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    for (int n = 0; n < 30; n++) begin
      if (n == wr_at) cfg_we = 1;
      cycle();
      cfg_we = 0;
      if (s_valid) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      chk("result_timeout", 0, 1);
      return;
    end
    hit = s_hit; alt = s_alt; id = s_id;
  endtask

  initial begin
    bit h, a, rose;
    int id, lat;

    reset = 0; cfg_we = 0; res_ready = 1; poll_valid = 0; poll_x = '0; poll_y = '0;
    load_cfg(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    reset = 1;
    cycle();
    chk("ready_after_reset", int'(s_ready), 1);
    chk("valid_after_reset", int'(s_valid), 0);

    // Solid box, inclusive far corner and one pixel beyond it.
    set_entry(0, 1, 0, 100, 50, 10, 8);
    poll(110, 58, -1, h, a, id, lat);
    chk("solid_corner_hit", h, 1); chk("solid_corner_id", id, 0); chk("solid_corner_lat", lat, 2);
    poll(111, 58, -1, h, a, id, lat);
    chk("solid_out_hit", h, 0); chk("solid_out_alt", a, 0); chk("solid_out_lat", lat, 5);

    // Overlapping entries: lowest index wins; then the later one.
    set_entry(1, 1, 0, 195, 95, 10, 10);
    set_entry(3, 1, 0, 200, 100, 0, 0);
    poll(200, 100, -1, h, a, id, lat);
    chk("overlap_hit", h, 1); chk("overlap_id", id, 1); chk("overlap_lat", lat, 3);
    set_entry(1, 0, 0, 195, 95, 10, 10);
    poll(200, 100, -1, h, a, id, lat);
    chk("disabled_hit", h, 1); chk("disabled_id", id, 3); chk("disabled_lat", lat, 5);

    // Dotted column: stripe hit, gap as alternate, zero width inert.
    set_entry(2, 1, 1, 320, 0, 4, 0);
    poll(322, 3, -1, h, a, id, lat);
    chk("dot_hit", h, 1); chk("dot_hit_id", id, 2); chk("dot_hit_lat", lat, 4);
    poll(322, 5, -1, h, a, id, lat);
    chk("dot_gap_hit", h, 0); chk("dot_gap_alt", a, 1); chk("dot_gap_id", id, 2);
    set_entry(2, 1, 1, 322, 0, 0, 0);
    poll(322, 5, -1, h, a, id, lat);
    chk("dot_w0_hit", h, 0); chk("dot_w0_alt", a, 0); chk("dot_w0_id", id, 0);

    // Box at the screen edge: extents must not wrap.
    set_entry(0, 1, 0, 1020, 500, 15, 15);
    poll(1023, 511, -1, h, a, id, lat);
    chk("edge_hit", h, 1); chk("edge_id", id, 0); chk("edge_lat", lat, 2);

    // Result held in DONE while res_ready is low; pending poll waits.
    res_ready = 0;
    poll(1023, 511, -1, h, a, id, lat);
    chk("hold_first_hit", h, 1);
    poll_x = 10'd200; poll_y = 9'd100; poll_valid = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("hold_valid", int'(s_valid), 1);
      chk("hold_hit", int'(s_hit), 1);
      chk("hold_id", s_id, 0);
      chk("hold_ready", int'(s_ready), 0);
    end
    res_ready = 1;
    cycle();
    poll(200, 100, -1, h, a, id, lat);
    chk("after_hold_hit", h, 1); chk("after_hold_id", id, 3); chk("after_hold_lat", lat, 5);

    // Entry 3 rewritten while entry 1 is being scanned.
    load_cfg(3, 1, 0, 400, 300, 2, 2);
    poll(400, 300, 1, h, a, id, lat);
    chk("midscan_cfg_hit", h, 1); chk("midscan_cfg_id", id, 3); chk("midscan_cfg_lat", lat, 5);

    // Reset during scan discards the poll and clears the table.
    poll_x = 10'd400; poll_y = 9'd300; poll_valid = 1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (s_ready) break;
    end
    poll_valid = 0;
    cycle();
    cycle();
    reset = 0;
    rose = 0;
    cycle(); rose |= s_valid;
    cycle(); rose |= s_valid;
    reset = 1;
    cycle();
    rose |= s_valid;
    chk("reset_ready_first", int'(s_ready), 1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      rose |= s_valid;
    end
    chk("reset_no_valid", int'(rose), 0);
    poll(400, 300, -1, h, a, id, lat);
    chk("cleared_hit", h, 0); chk("cleared_alt", a, 0); chk("cleared_lat", lat, 5);

    repeat (2) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
